// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU bus decoder and its OAM DMA engine.
// Optional OAM DMA engine is enabled with the NES_BUS_OAM_DMA_EN macro.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    REGION_RAM  = 3'd0,
    REGION_PPU  = 3'd1,
    REGION_IO   = 3'd2,
    REGION_PRG  = 3'd3,
    REGION_NONE = 3'd4
  } region_e;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PPU_LIMIT = 16'h3FFF;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] IO_LIMIT  = 16'h401F;
  localparam logic [15:0] PRG_BASE  = 16'h8000;
  localparam logic [15:0] PRG_LIMIT = 16'hFFFF;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [2:0]  OAM_DATA_REG  = 3'd4;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_RD    = 3'd3,
    DMA_WR    = 3'd4
  } dma_state_e;

  // RAM starts at address zero and PRG runs to the top of the map, so those
  // two regions only need their inner bound checked.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    if (addr <= RAM_LIMIT) begin
      r = REGION_RAM;
    end else if ((addr >= PPU_BASE) && (addr <= PPU_LIMIT)) begin
      r = REGION_PPU;
    end else if ((addr >= IO_BASE) && (addr <= IO_LIMIT)) begin
      r = REGION_IO;
    end else if (addr >= PRG_BASE) begin
      r = REGION_PRG;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// OAM DMA engine: halts the CPU, optionally aligns to the read/write parity,
// then copies 256 bytes from page P to the PPU OAM data register.
module nes_oam_dma
  import nes_bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [7:0]  page,
  output logic        busy,
  output logic        rd_cycle,
  output logic        wr_cycle,
  output logic [15:0] rd_addr
);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic       parity_q, parity_d;
  logic       busy_q, busy_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;

  // Next-state logic for the transfer sequencer and its registered strobes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    page_d   = page_q;
    parity_d = ~parity_q;
    case (state_q)
      DMA_IDLE: begin
        if (trigger) begin
          state_d = DMA_HALT;
          page_d  = page;
        end else begin
          state_d = DMA_IDLE;
        end
      end
      DMA_HALT: begin
        if (parity_q) begin
          state_d = DMA_ALIGN;
        end else begin
          state_d = DMA_RD;
        end
      end
      DMA_ALIGN: state_d = DMA_RD;
      DMA_RD:    state_d = DMA_WR;
      DMA_WR: begin
        if (idx_q == 8'hFF) begin
          state_d = DMA_IDLE;
          idx_d   = 8'h00;
        end else begin
          state_d = DMA_RD;
          idx_d   = idx_q + 8'h01;
        end
      end
      default: begin
        state_d = DMA_IDLE;
        idx_d   = 8'h00;
      end
    endcase
    busy_d = (state_d != DMA_IDLE);
    rd_d   = (state_d == DMA_RD);
    wr_d   = (state_d == DMA_WR);
  end

  // Sequencer state, transfer index, page and parity registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= DMA_IDLE;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign busy     = busy_q;
  assign rd_cycle = rd_q;
  assign wr_cycle = wr_q;
  assign rd_addr  = {page_q, idx_q};

endmodule

// File: rtl/nes_bus.sv
// NES CPU bus: address decode to RAM/PPU/IO/PRG, registered read-return
// region, open-bus latch, and (with NES_BUS_OAM_DMA_EN) the OAM DMA engine.
module nes_bus
  import nes_bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_o_data,
  input  logic        cpu_wren,
  input  logic        cpu_read,
  output logic [7:0]  cpu_i_data,
  output logic        cpu_ready,
  output logic [10:0] ram_address,
  output logic [7:0]  ram_o_data,
  output logic        ram_wren,
  input  logic [7:0]  ram_i_data,
  output logic [2:0]  ppu_reg,
  output logic [7:0]  ppu_o_data,
  output logic        ppu_wren,
  output logic        ppu_read,
  input  logic [7:0]  ppu_i_data,
  output logic [4:0]  io_address,
  output logic [7:0]  io_o_data,
  output logic        io_wren,
  output logic        io_read,
  input  logic [7:0]  io_i_data,
  output logic [14:0] prg_address,
  input  logic [7:0]  prg_i_data
);

  logic        dma_busy_s, dma_rd_s, dma_wr_s, dma_trigger_s;
  logic [15:0] dma_addr_s;

  logic        cpu_rd_ok_s, cpu_wr_ok_s;
  logic [15:0] bus_addr_s;
  logic        bus_rd_s, bus_wr_s;
  region_e     region_s;
  logic [7:0]  rdata_s;

  region_e     region_q, region_d;
  logic        read_q, read_d;
  logic [7:0]  open_bus_q, open_bus_d;

`ifdef NES_BUS_OAM_DMA_EN
  assign dma_trigger_s = cpu_wren & cpu_ready & reset_n & (cpu_address == DMA_TRIG_ADDR);

  nes_oam_dma u_oam_dma (
    .clock    (clock),
    .reset_n  (reset_n),
    .trigger  (dma_trigger_s),
    .page     (cpu_o_data),
    .busy     (dma_busy_s),
    .rd_cycle (dma_rd_s),
    .wr_cycle (dma_wr_s),
    .rd_addr  (dma_addr_s)
  );
`else
  assign dma_trigger_s = 1'b0;
  assign dma_busy_s    = 1'b0;
  assign dma_rd_s      = 1'b0;
  assign dma_wr_s      = 1'b0;
  assign dma_addr_s    = 16'h0000;
`endif

  assign cpu_ready = ~dma_busy_s;

  // Choose the bus master (DMA read slot or CPU) and gate CPU strobes.
  always_comb begin
    cpu_rd_ok_s = cpu_read & cpu_ready & reset_n;
    cpu_wr_ok_s = cpu_wren & cpu_ready & reset_n;
    if (dma_rd_s) begin
      bus_addr_s = dma_addr_s;
      bus_rd_s   = 1'b1;
      bus_wr_s   = 1'b0;
    end else begin
      bus_addr_s = cpu_address;
      bus_rd_s   = cpu_rd_ok_s;
      bus_wr_s   = cpu_wr_ok_s & ~dma_trigger_s;
    end
    region_s = decode_region(bus_addr_s);
  end

  // Return data follows the region registered on the previous edge.
  always_comb begin
    case (region_q)
      REGION_RAM: rdata_s = ram_i_data;
      REGION_PPU: rdata_s = ppu_i_data;
      REGION_IO:  rdata_s = io_i_data;
      REGION_PRG: rdata_s = prg_i_data;
      default:    rdata_s = open_bus_q;
    endcase
  end

  assign cpu_i_data = rdata_s;

  // Drive each device port; strobes reach only the selected region.
  always_comb begin
    ram_address = bus_addr_s[10:0];
    ram_o_data  = cpu_o_data;
    ram_wren    = bus_wr_s && (region_s == REGION_RAM);
    ppu_read    = bus_rd_s && (region_s == REGION_PPU);
    if (dma_wr_s) begin
      ppu_reg    = OAM_DATA_REG;
      ppu_o_data = rdata_s;
      ppu_wren   = 1'b1;
    end else begin
      ppu_reg    = bus_addr_s[2:0];
      ppu_o_data = cpu_o_data;
      ppu_wren   = bus_wr_s && (region_s == REGION_PPU);
    end
    io_address  = bus_addr_s[4:0];
    io_o_data   = cpu_o_data;
    io_wren     = bus_wr_s && (region_s == REGION_IO);
    io_read     = bus_rd_s && (region_s == REGION_IO);
    prg_address = bus_addr_s[14:0];
  end

  // Open-bus latch tracks the last byte driven onto or returned by the bus;
  // a write in the same cycle as a returning read is the later event.
  always_comb begin
    region_d = region_s;
    read_d   = bus_rd_s;
    if (dma_wr_s) begin
      open_bus_d = rdata_s;
    end else if (cpu_wr_ok_s) begin
      open_bus_d = cpu_o_data;
    end else if (read_q) begin
      open_bus_d = rdata_s;
    end else begin
      open_bus_d = open_bus_q;
    end
  end

  // Read-return region, read-pending flag and open-bus registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      region_q   <= REGION_RAM;
      read_q     <= 1'b0;
      open_bus_q <= 8'h00;
    end else begin
      region_q   <= region_d;
      read_q     <= read_d;
      open_bus_q <= open_bus_d;
    end
  end

endmodule

// File: tb/tb_nes_bus.sv
// Randomised and directed bench for nes_bus against a behavioural bus model.
module tb_nes_bus;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o_data;
  logic        cpu_wren, cpu_read;
  logic [7:0]  cpu_i_data;
  logic        cpu_ready;
  logic [10:0] ram_address;
  logic [7:0]  ram_o_data, ram_i_data;
  logic        ram_wren;
  logic [2:0]  ppu_reg;
  logic [7:0]  ppu_o_data, ppu_i_data;
  logic        ppu_wren, ppu_read;
  logic [4:0]  io_address;
  logic [7:0]  io_o_data, io_i_data;
  logic        io_wren, io_read;
  logic [14:0] prg_address;
  logic [7:0]  prg_i_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  nes_bus dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_o_data(cpu_o_data), .cpu_wren(cpu_wren),
    .cpu_read(cpu_read), .cpu_i_data(cpu_i_data), .cpu_ready(cpu_ready),
    .ram_address(ram_address), .ram_o_data(ram_o_data), .ram_wren(ram_wren),
    .ram_i_data(ram_i_data),
    .ppu_reg(ppu_reg), .ppu_o_data(ppu_o_data), .ppu_wren(ppu_wren),
    .ppu_read(ppu_read), .ppu_i_data(ppu_i_data),
    .io_address(io_address), .io_o_data(io_o_data), .io_wren(io_wren),
    .io_read(io_read), .io_i_data(io_i_data),
    .prg_address(prg_address), .prg_i_data(prg_i_data)
  );

  function automatic logic [7:0] ppu_value(input logic [2:0] r);
    return 8'h30 + {5'b00000, r};
  endfunction
  function automatic logic [7:0] io_value(input logic [4:0] a);
    return 8'h60 ^ {3'b000, a};
  endfunction
  function automatic logic [7:0] prg_value(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction
  function automatic int region_of(input logic [15:0] a);
    if (a < 16'h2000) return 0;
    else if (a < 16'h4000) return 1;
    else if (a < 16'h4020) return 2;
    else if (a >= 16'h8000) return 3;
    else return 4;
  endfunction

  // Device models: synchronous 1-cycle read latency.
  logic [7:0] ram_mem [0:2047];
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_o_data;
    ram_i_data <= ram_mem[ram_address];
    ppu_i_data <= ppu_value(ppu_reg);
    io_i_data  <= io_value(io_address);
    prg_i_data <= prg_value(prg_address);
  end

  // Cycle count since reset release; its LSB is the expected bus parity.
  int pc;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc <= 0;
    else pc <= pc + 1;
  end

  // Log of every PPU write as {reg, data}.
  logic [10:0] ppu_q [$];
  always @(posedge clock) begin
    if (reset_n && ppu_wren) ppu_q.push_back({ppu_reg, ppu_o_data});
  end

  // Reference model state.
  logic [7:0] shadow [0:2047];
  logic [7:0] ob = 8'h00;
  logic       pend_rd = 1'b0;
  logic [7:0] pend_exp = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_op(input logic [15:0] a, input logic wr, input logic rd, input logic [7:0] d);
    int r;
    logic [4:0]  exp_s, got_s;
    logic [15:0] exp_a, got_a;
    logic [7:0]  got_d;
    @(negedge clock);
    cpu_address = a; cpu_wren = wr; cpu_read = rd; cpu_o_data = d;
    #1;
    if (pend_rd) begin
      check_eq("rdata", {24'h0, cpu_i_data}, {24'h0, pend_exp});
      ob = pend_exp;
    end
    r = region_of(a);
    got_s = {ram_wren, ppu_wren, ppu_read, io_wren, io_read};
    case (r)
      0:       exp_s = {wr, 4'b0000};
      1:       exp_s = {1'b0, wr, rd, 2'b00};
      2:       exp_s = {3'b000, wr, rd};
      default: exp_s = 5'b00000;
    endcase
    check_eq("strobes", {27'h0, got_s}, {27'h0, exp_s});
    if ((wr || rd) && (r != 4)) begin
      case (r)
        0:       begin got_a = {5'h00, ram_address};  exp_a = {5'h00, a[10:0]}; got_d = ram_o_data; end
        1:       begin got_a = {13'h0, ppu_reg};      exp_a = {13'h0, a[2:0]};  got_d = ppu_o_data; end
        2:       begin got_a = {11'h0, io_address};   exp_a = {11'h0, a[4:0]};  got_d = io_o_data;  end
        default: begin got_a = {1'b0, prg_address};   exp_a = {1'b0, a[14:0]};  got_d = d;          end
      endcase
      check_eq("port_addr", {16'h0, got_a}, {16'h0, exp_a});
      if (wr) check_eq("port_wdata", {24'h0, got_d}, {24'h0, d});
    end
    if (wr) begin
      ob = d;
      if (r == 0) shadow[a[10:0]] = d;
    end
    pend_rd = rd;
    if (rd) begin
      case (r)
        0:       pend_exp = shadow[a[10:0]];
        1:       pend_exp = ppu_value(a[2:0]);
        2:       pend_exp = io_value(a[4:0]);
        3:       pend_exp = prg_value(a[14:0]);
        default: pend_exp = ob;
      endcase
    end
  endtask

`ifdef NES_BUS_OAM_DMA_EN
  // Launch a DMA from page 2 so that the HALT cycle has parity halt_par.
  // abort_at >= 0 pulses reset during the WR of that transfer index.
  task automatic run_dma(input logic halt_par, input int abort_at);
    int low, stray, errs;
    logic done;
    low = 0; stray = 0; errs = 0; done = 1'b0;
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);
    pend_rd = 1'b0;
    @(negedge clock);
    while (pc[0] == halt_par) begin
      @(negedge clock);
    end
    ppu_q.delete();
    cpu_address = 16'h4014; cpu_wren = 1'b1; cpu_read = 1'b0; cpu_o_data = 8'h02;
    #1;
    check_eq("trig_io_wren", {31'h0, io_wren}, 32'h0);
    check_eq("trig_ready", {31'h0, cpu_ready}, 32'h1);
    for (int c = 0; c < 1200; c++) begin
      @(negedge clock);
      cpu_address = 16'h0210; cpu_wren = 1'b1; cpu_read = 1'b1; cpu_o_data = 8'hFF;
      #1;
      if (cpu_ready) begin
        cpu_wren = 1'b0; cpu_read = 1'b0;
        done = 1'b1;
        break;
      end
      low++;
      if (ram_wren || io_wren || io_read) stray++;
      if ((abort_at >= 0) && (ppu_q.size() == abort_at) && ppu_wren) begin
        reset_n = 1'b0; cpu_wren = 1'b0; cpu_read = 1'b0;
        #1;
        check_eq("abort_ready", {31'h0, cpu_ready}, 32'h1);
        check_eq("abort_ppu_wren", {31'h0, ppu_wren}, 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (600) @(negedge clock);
        check_eq("abort_no_more_wr", ppu_q.size(), abort_at);
        check_eq("abort_ready_after", {31'h0, cpu_ready}, 32'h1);
        ob = 8'h00;
        return;
      end
    end
    check_eq("dma_done", {31'h0, done}, 32'h1);
    check_eq("dma_low_cycles", low, halt_par ? 514 : 513);
    check_eq("dma_stray", stray, 0);
    check_eq("dma_wr_count", ppu_q.size(), 256);
    for (int i = 0; i < ppu_q.size(); i++) begin
      if (ppu_q[i] !== {3'd4, i[7:0]}) errs++;
    end
    check_eq("dma_data_errs", errs, 0);
    ob = 8'hFF;
    bus_op(16'h0210, 1'b0, 1'b1, 8'h00);
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask
`endif

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          r, k;
    int          low;

    reset_n = 1'b0;
    cpu_address = 16'h0100; cpu_o_data = 8'h11; cpu_wren = 1'b1; cpu_read = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_ready", {31'h0, cpu_ready}, 32'h1);
    check_eq("rst_strobes", {27'h0, ram_wren, ppu_wren, ppu_read, io_wren, io_read}, 32'h0);
    cpu_address = 16'h2002;
    #1;
    check_eq("rst_strobes_ppu", {30'h0, ppu_wren, ppu_read}, 32'h0);
    @(negedge clock);
    cpu_wren = 1'b0; cpu_read = 1'b0;
    reset_n = 1'b1;

    // Fill RAM through the CPU port.
    for (int i = 0; i < 2048; i++) begin
      a = i[15:0];
      d = a[7:0] ^ (8'd37 * {5'b00000, a[10:8]});
      bus_op(a, 1'b1, 1'b0, d);
    end

    // RAM mirroring: write $0801, read $0001.
    bus_op(16'h0801, 1'b1, 1'b0, 8'h5A);
    bus_op(16'h0001, 1'b0, 1'b1, 8'h00);
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);
    check_eq("ram_mirror", {24'h0, cpu_i_data}, 32'h5A);

    // PPU mirrored register read.
    bus_op(16'h3FFA, 1'b0, 1'b1, 8'h00);
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);
    check_eq("ppu_read_data", {24'h0, cpu_i_data}, {24'h0, ppu_value(3'd2)});

    // Open bus after a PRG read.
    bus_op(16'h80AB, 1'b0, 1'b1, 8'h00);
    bus_op(16'h5000, 1'b0, 1'b1, 8'h00);
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);
    check_eq("open_bus", {24'h0, cpu_i_data}, 32'hAB);

    // Randomised traffic over all regions.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0:       a = $urandom_range(16'h0000, 16'h1FFF);
        1:       a = $urandom_range(16'h2000, 16'h3FFF);
        2:       a = $urandom_range(16'h4000, 16'h401F);
        3:       a = $urandom_range(16'h8000, 16'hFFFF);
        default: a = $urandom_range(16'h4020, 16'h7FFF);
      endcase
      k = $urandom_range(0, 2);
      if ((a == 16'h4014) && (k == 1)) a = 16'h4015;
      d = 8'($urandom);
      bus_op(a, (k == 1), (k == 2), d);
    end
    bus_op(16'h0000, 1'b0, 1'b0, 8'h00);

`ifdef NES_BUS_OAM_DMA_EN
    for (int i = 0; i < 256; i++) begin
      a = 16'h0200 + i[15:0];
      bus_op(a, 1'b1, 1'b0, i[7:0]);
    end
    run_dma(1'b0, -1);
    run_dma(1'b1, -1);
    run_dma(1'b0, 100);
`else
    // Without the DMA engine $4014 is an ordinary IO write.
    bus_op(16'h4014, 1'b1, 1'b0, 8'h02);
    low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      cpu_wren = 1'b0; cpu_read = 1'b0;
      #1;
      if (!cpu_ready) low++;
    end
    check_eq("nodma_ready", low, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
